// File: rtl/cp0_if.sv
// CP0 access bundle between the pipeline (master) and the CP0 register file (slave).
interface cp0_if;
  logic        cp_read_en;
  logic [4:0]  cp_read_addr;
  logic [31:0] cp_read_data;
  logic        cp_write_en;
  logic [4:0]  cp_write_addr;
  logic [31:0] cp_write_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay_slot;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        int_pending;

  modport master (
    output cp_read_en, cp_read_addr, cp_write_en, cp_write_addr, cp_write_data,
    output exc_valid, exc_code, exc_pc, exc_in_delay_slot, exc_badvaddr, eret, hw_int,
    input  cp_read_data, status, cause, epc, int_pending
  );

  modport slave (
    input  cp_read_en, cp_read_addr, cp_write_en, cp_write_addr, cp_write_data,
    input  exc_valid, exc_code, exc_pc, exc_in_delay_slot, exc_badvaddr, eret, hw_int,
    output cp_read_data, status, cause, epc, int_pending
  );
endinterface

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: BadVAddr, Count/Compare timer, Status, Cause, EPC,
// exception entry, ERET and interrupt request generation.
module cp0_regs #(
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
  parameter int          COUNT_DIV    = 2
) (
  input logic  clk,
  input logic  rst,
  cp0_if.slave bus
);

  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;
  localparam logic [31:0] STATUS_BEV    = 32'h0040_0000;
  localparam logic        DIV_LAST      = 1'(COUNT_DIV - 1);

  logic [31:0] badvaddr_r, count_r, compare_r, status_r, cause_r, epc_r;
  logic        div_r;
  logic [31:0] badvaddr_s, count_s, compare_s, status_s, cause_s, epc_s;
  logic        div_s, tick_s, wr_count_s, wr_compare_s;

  // Next-state for timer, exception entry, ERET and MTC0 updates.
  always_comb begin
    badvaddr_s   = badvaddr_r;
    count_s      = count_r;
    compare_s    = compare_r;
    status_s     = status_r;
    cause_s      = cause_r;
    epc_s        = epc_r;
    tick_s       = (div_r == DIV_LAST);
    div_s        = tick_s ? 1'b0 : div_r + 1'b1;
    wr_count_s   = bus.cp_write_en && (bus.cp_write_addr == ADDR_COUNT);
    wr_compare_s = bus.cp_write_en && (bus.cp_write_addr == ADDR_COMPARE);

    if (wr_count_s) begin
      count_s = bus.cp_write_data;
    end else if (tick_s) begin
      count_s = count_r + 32'd1;
    end else begin
      count_s = count_r;
    end

    if (wr_compare_s) begin
      compare_s   = bus.cp_write_data;
      cause_s[30] = 1'b0;
    end else if (count_r == compare_r) begin
      cause_s[30] = 1'b1;
    end else begin
      cause_s[30] = cause_r[30];
    end

    // The timer folds into IP7 using the TI value held before this edge.
    cause_s[15:10] = {bus.hw_int[5] | cause_r[30], bus.hw_int[4:0]};

    if (bus.exc_valid) begin
      if (!status_r[1]) begin
        epc_s       = bus.exc_in_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
        cause_s[31] = bus.exc_in_delay_slot;
      end else begin
        epc_s       = epc_r;
        cause_s[31] = cause_r[31];
      end
      status_s[1]  = 1'b1;
      cause_s[6:2] = bus.exc_code;
      if ((bus.exc_code == 5'd4) || (bus.exc_code == 5'd5)) begin
        badvaddr_s = bus.exc_badvaddr;
      end else begin
        badvaddr_s = badvaddr_r;
      end
    end else if (bus.eret) begin
      status_s[1] = 1'b0;
    end else if (bus.cp_write_en) begin
      case (bus.cp_write_addr)
        ADDR_STATUS: status_s     = (bus.cp_write_data & STATUS_WMASK) | STATUS_BEV;
        ADDR_CAUSE:  cause_s[9:8] = bus.cp_write_data[9:8];
        ADDR_EPC:    epc_s        = bus.cp_write_data;
        default:     epc_s        = epc_r;
      endcase
    end else begin
      status_s = status_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr_r <= 32'h0;
      count_r    <= 32'h0;
      compare_r  <= 32'h0;
      status_r   <= STATUS_RESET;
      cause_r    <= 32'h0;
      epc_r      <= 32'h0;
      div_r      <= 1'b0;
    end else begin
      badvaddr_r <= badvaddr_s;
      count_r    <= count_s;
      compare_r  <= compare_s;
      status_r   <= status_s;
      cause_r    <= cause_s;
      epc_r      <= epc_s;
      div_r      <= div_s;
    end
  end

  // MFC0 read mux; unmapped registers read as zero.
  always_comb begin
    bus.cp_read_data = 32'h0;
    if (bus.cp_read_en) begin
      case (bus.cp_read_addr)
        ADDR_BADVADDR: bus.cp_read_data = badvaddr_r;
        ADDR_COUNT:    bus.cp_read_data = count_r;
        ADDR_COMPARE:  bus.cp_read_data = compare_r;
        ADDR_STATUS:   bus.cp_read_data = status_r;
        ADDR_CAUSE:    bus.cp_read_data = cause_r;
        ADDR_EPC:      bus.cp_read_data = epc_r;
        default:       bus.cp_read_data = 32'h0;
      endcase
    end else begin
      bus.cp_read_data = 32'h0;
    end
  end

  assign bus.status      = status_r;
  assign bus.cause       = cause_r;
  assign bus.epc         = epc_r;
  assign bus.int_pending = status_r[0] & ~status_r[1] & (|(cause_r[15:8] & status_r[15:8]));

endmodule

// File: tb/tb_cp0_regs.sv
// Randomized self-checking bench for cp0_regs against a field-level CP0 model.
module tb_cp0_regs;
  localparam int DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  cp0_if bus ();

  cp0_regs #(.STATUS_RESET(32'h0040_0000), .COUNT_DIV(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, kept as separate architectural fields.
  logic [31:0] m_count, m_compare, m_badv, m_epc;
  logic [7:0]  m_im;
  logic        m_ie, m_exl, m_bd, m_ti;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  int          m_phase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | ({24'd0, m_im} << 8) | ({31'd0, m_exl} << 1) | {31'd0, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return ({31'd0, m_bd} << 31) | ({31'd0, m_ti} << 30) | ({26'd0, m_iphw} << 10)
         | ({30'd0, m_ipsw} << 8) | ({27'd0, m_code} << 2);
  endfunction

  function automatic logic m_intp();
    logic [7:0] ip;
    ip = {m_iphw, m_ipsw};
    return m_ie && !m_exl && ((ip & m_im) != 8'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic en, input logic [4:0] a);
    if (!en) return 32'h0;
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 32'h0; m_compare = 32'h0; m_badv = 32'h0; m_epc = 32'h0;
    m_im = 8'h0; m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
    m_iphw = 6'h0; m_ipsw = 2'h0; m_code = 5'h0; m_phase = 0;
  endtask

  // Apply one clock edge's worth of architectural effects to the model.
  task automatic model_update();
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d, n_count;
    logic        n_ti;
    wr = bus.cp_write_en; a = bus.cp_write_addr; d = bus.cp_write_data;
    if (wr && a == 5'd9) n_count = d;
    else if ((m_phase % DIV) == DIV - 1) n_count = m_count + 32'd1;
    else n_count = m_count;
    if (wr && a == 5'd11) n_ti = 1'b0;
    else if (m_count == m_compare) n_ti = 1'b1;
    else n_ti = m_ti;
    m_iphw = {bus.hw_int[5] | m_ti, bus.hw_int[4:0]};
    if (wr && a == 5'd11) m_compare = d;
    if (bus.exc_valid) begin
      if (!m_exl) begin
        m_epc = bus.exc_in_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
        m_bd  = bus.exc_in_delay_slot;
      end
      m_exl  = 1'b1;
      m_code = bus.exc_code;
      if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) m_badv = bus.exc_badvaddr;
    end else if (bus.eret) begin
      m_exl = 1'b0;
    end else if (wr) begin
      case (a)
        5'd12: begin m_im = d[15:8]; m_exl = d[1]; m_ie = d[0]; end
        5'd13: m_ipsw = d[9:8];
        5'd14: m_epc = d;
        default: ;
      endcase
    end
    m_count = n_count;
    m_ti    = n_ti;
    m_phase++;
  endtask

  task automatic idle();
    bus.cp_read_en = 1'b0; bus.cp_read_addr = 5'd0;
    bus.cp_write_en = 1'b0; bus.cp_write_addr = 5'd0; bus.cp_write_data = 32'h0;
    bus.exc_valid = 1'b0; bus.exc_code = 5'd0; bus.exc_pc = 32'h0;
    bus.exc_in_delay_slot = 1'b0; bus.exc_badvaddr = 32'h0; bus.eret = 1'b0;
    bus.hw_int = 6'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp_write_en = 1'b1; bus.cp_write_addr = a; bus.cp_write_data = d;
  endtask

  // Called just after a rising edge: compare outputs at the falling edge, then advance.
  task automatic step();
    @(negedge clk);
    check("read_data", bus.cp_read_data, m_read(bus.cp_read_en, bus.cp_read_addr));
    check("status", bus.status, m_status());
    check("cause", bus.cause, m_cause());
    check("epc", bus.epc, m_epc);
    check("int_pending", {31'd0, bus.int_pending}, {31'd0, m_intp()});
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    int r;
    logic [4:0] addrs [8];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd0};
    idle();
    bus.cp_read_en   = ($urandom_range(0, 7) != 0);
    bus.cp_read_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
    bus.hw_int       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
    if ($urandom_range(0, 3) == 0) begin
      bus.cp_write_en   = 1'b1;
      bus.cp_write_addr = addrs[$urandom_range(0, 7)];
      r = $urandom_range(0, 3);
      if (r == 0) bus.cp_write_data = m_count + 32'($urandom_range(0, 6));
      else if (r == 1) bus.cp_write_data = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      else bus.cp_write_data = $urandom;
    end
    if ($urandom_range(0, 15) == 0) begin
      bus.exc_valid         = 1'b1;
      bus.exc_code          = ($urandom_range(0, 1) == 0) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom);
      bus.exc_pc            = $urandom;
      bus.exc_in_delay_slot = 1'($urandom);
      bus.exc_badvaddr      = $urandom;
    end
    bus.eret = ($urandom_range(0, 11) == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset values before the first edge after release.
    bus.cp_read_en = 1'b1; bus.cp_read_addr = 5'd12; #1;
    check("rst_status_rd", bus.cp_read_data, 32'h0040_0000);
    bus.cp_read_addr = 5'd13; #1;
    check("rst_cause_rd", bus.cp_read_data, 32'h0);
    bus.cp_read_addr = 5'd9; #1;
    check("rst_count_rd", bus.cp_read_data, 32'h0);
    check("rst_int_pending", {31'd0, bus.int_pending}, 32'd0);

    repeat (10) step();
    #1;
    check("count_after_10", bus.cp_read_data, 32'd5);

    idle(); mtc0(5'd11, 32'd8); step();
    idle(); mtc0(5'd12, 32'h0000_8001); step();
    idle(); bus.cp_read_en = 1'b1; bus.cp_read_addr = 5'd9;
    repeat (8) step();
    check("ti_set", {31'd0, bus.cause[30]}, 32'd1);
    check("ip7_set", {31'd0, bus.cause[15]}, 32'd1);
    check("timer_int", {31'd0, bus.int_pending}, 32'd1);
    idle(); mtc0(5'd11, 32'd100); step();
    check("ti_cleared", {31'd0, bus.cause[30]}, 32'd0);

    idle(); bus.exc_valid = 1'b1; bus.exc_code = 5'd4; bus.exc_pc = 32'hBFC0_0104;
    bus.exc_in_delay_slot = 1'b1; bus.exc_badvaddr = 32'h1235; step();
    idle(); bus.cp_read_en = 1'b1; bus.cp_read_addr = 5'd8; #1;
    check("exc_epc", bus.epc, 32'hBFC0_0100);
    check("exc_bd", {31'd0, bus.cause[31]}, 32'd1);
    check("exc_code", {27'd0, bus.cause[6:2]}, 32'd4);
    check("exc_badvaddr", bus.cp_read_data, 32'h1235);
    check("exc_exl", {31'd0, bus.status[1]}, 32'd1);
    check("exc_int_masked", {31'd0, bus.int_pending}, 32'd0);

    idle(); bus.exc_valid = 1'b1; bus.exc_code = 5'd8; bus.exc_pc = 32'h200; step();
    check("nested_epc", bus.epc, 32'hBFC0_0100);
    check("nested_code", {27'd0, bus.cause[6:2]}, 32'd8);
    idle(); bus.eret = 1'b1; step();
    check("eret_exl", {31'd0, bus.status[1]}, 32'd0);

    idle(); bus.exc_valid = 1'b1; mtc0(5'd12, 32'h0); step();
    check("prio_exl", {31'd0, bus.status[1]}, 32'd1);
    check("prio_ie", {31'd0, bus.status[0]}, 32'd1);

    idle(); mtc0(5'd9, 32'hFFFF_FFFF); step();
    idle(); bus.cp_read_en = 1'b1; bus.cp_read_addr = 5'd9;
    for (int i = 0; i < 4 && m_count == 32'hFFFF_FFFF; i++) step();
    #1;
    check("count_wrap", bus.cp_read_data, 32'h0);
    idle(); mtc0(5'd3, 32'hFFFF); step();
    idle(); bus.cp_read_en = 1'b1; bus.cp_read_addr = 5'd3; #1;
    check("unmapped_rd", bus.cp_read_data, 32'h0);
    step();

    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 register file for the ID/EX datapath; consumes the CP0 read/write address and enable signals that the ID stage generates for MFC0/MTC0.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Runs the Count/Compare timer, records exception entry, handles ERET and produces the interrupt request to the pipeline controller.

Parameters:
- STATUS_RESET, 32'h0040_0000, Status reset value (BEV=1, all other bits 0).
- COUNT_DIV, 2, clock cycles per Count increment; legal values 1 or 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cp_read_en  in  1  MFC0 read enable.
- cp_read_addr  in  5  CP0 register number to read.
- cp_read_data  out  32  read data, combinational.
- cp_write_en  in  1  MTC0 write enable.
- cp_write_addr  in  5  CP0 register number to write.
- cp_write_data  in  32  MTC0 data (GPR rt value).
- exc_valid  in  1  exception commits this cycle.
- exc_code  in  5  ExcCode value.
- exc_pc  in  32  PC of the faulting instruction.
- exc_in_delay_slot  in  1  faulting instruction is in a branch delay slot.
- exc_badvaddr  in  32  faulting address for AdEL/AdES.
- eret  in  1  ERET commits this cycle.
- hw_int  in  6  external interrupt lines, level-sensitive.
- status  out  32  current Status register.
- cause  out  32  current Cause register.
- epc  out  32  current EPC register.
- int_pending  out  1  unmasked interrupt is present.

Behaviour:
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Every other address reads 32'h0; writes to them are ignored.
- Reset (rst=0, asynchronous):
  - Status = STATUS_RESET.
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - Tick divider = 0.
  - int_pending = 0.
- Read path:
  - cp_read_data = selected register when cp_read_en=1, otherwise 0.
  - No write-to-read bypass: a write becomes visible the cycle after the clock edge.
- Write masks:
  - Status: only IM[15:8], EXL[1] and IE[0] are writable; BEV[22] stays 1; all other bits read 0.
  - Cause: only IP[9:8] (software interrupts) are writable.
  - EPC, Count, Compare: fully writable.
  - BadVAddr: read-only.
- Count timer:
  - The divider counts 0..COUNT_DIV-1; Count increments by 1 on each cycle the divider is at COUNT_DIV-1.
  - Count wraps from 32'hFFFF_FFFF to 0.
  - An MTC0 to Count loads the written value, which takes priority over the increment that cycle; the divider is not reset.
- Timer interrupt (TI, Cause[30]):
  - Set on the edge after the registered Count equals Compare.
  - An MTC0 to Compare clears TI; if set and clear happen in the same cycle, clear wins.
  - TI remains set until Compare is written.
- Cause.IP[15:10] is registered every cycle from {hw_int[5] | TI, hw_int[4:0]}.
- Exception entry (exc_valid=1):
  - If Status.EXL=0: EPC = exc_in_delay_slot ? exc_pc-4 : exc_pc, and Cause.BD[31] = exc_in_delay_slot.
  - If Status.EXL=1: EPC and BD are left unchanged.
  - Always: Status.EXL=1 and Cause.ExcCode[6:2]=exc_code.
  - BadVAddr = exc_badvaddr only when exc_code is 4 (AdEL) or 5 (AdES).
- ERET (with exc_valid=0): Status.EXL=0.
- Same-cycle priority on Status/Cause/EPC/BadVAddr fields: exc_valid > eret > MTC0. An MTC0 to Count/Compare is still applied in a cycle that also has exc_valid.
- int_pending (combinational) = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]).
- Outputs status, cause and epc are direct register values.

Test Plan:
- Release reset, read addr 12, 13, 9 -> 32'h0040_0000, 0, 0; 10 cycles later with COUNT_DIV=2, Count=5.
- MTC0 Compare=8, MTC0 Status=32'h0000_8001 -> when Count reaches 8, Cause[30]=1 and Cause[15]=1 on the next edge, int_pending=1; MTC0 Compare=100 -> Cause[30]=0 the next cycle.
- exc_valid with code 4, exc_pc=32'hBFC0_0104, in_delay_slot=1, badvaddr=32'h1235 -> EPC=32'hBFC0_0100, BD=1, ExcCode=4, BadVAddr=32'h1235, EXL=1, int_pending=0.
- A second exception while EXL=1 (code 8, pc 32'h200) -> EPC unchanged, ExcCode=8; then eret -> EXL=0.
- Same cycle: exc_valid (code 0) plus MTC0 Status=0 -> EXL=1, IE unchanged.
- MTC0 Count=32'hFFFF_FFFF -> Count reads 0 after one increment; MTC0 addr 3=32'hFFFF, then read addr 3 -> 0.
